// File: rtl/wb_regbank_n.sv
// Parametrised pipelined-Wishbone register bank: NREGS x WIDTH control/status
// registers with byte-lane writes, per-register write strobes and bus errors.
module wb_regbank_n #(
  parameter int               NREGS     = 4,
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [NREGS-1:0] RO_MASK   = '0,
  localparam int              AW        = $clog2(NREGS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic [AW+1:2]          wb_adr_i,
  input  logic [3:0]             wb_sel_i,
  input  logic                   wb_we_i,
  input  logic [31:0]            wb_dat_i,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic                   wb_rty_o,
  output logic                   wb_stall_o,
  output logic [31:0]            wb_dat_o,
  output logic [NREGS*WIDTH-1:0] ctrl_o,
  output logic [NREGS-1:0]       ctrl_wr_o,
  input  logic [NREGS*WIDTH-1:0] sts_i
);

  logic [WIDTH-1:0] regs [NREGS];

  logic          en, rd_req, wr_req;
  logic          rip, wip, wr_done_q;
  logic [AW-1:0] rd_idx;
  logic          rd_hit;
  logic [WIDTH-1:0] rd_val;

  logic             d0_valid;
  logic [AW-1:0]    d0_idx;
  logic [3:0]       d0_sel;
  logic [WIDTH-1:0] d0_dat;
  logic [31:0]      d0_bmask;
  logic             d0_hit, d0_ro, d0_legal, d0_any;

  assign en         = wb_cyc_i & wb_stb_i;
  assign rd_req     = en & ~wb_we_i & ~rip;
  assign wr_req     = en & wb_we_i & ~wip;
  assign rd_idx     = wb_adr_i;
  assign wb_stall_o = en & ~(wb_ack_o | wb_err_o);
  assign wb_rty_o   = 1'b0;

  // Upper data bits are simply dropped when WIDTH < 32.
  logic unused_dat;
  assign unused_dat = ^wb_dat_i;

  // NOTE: every variable gets a default before the loop, so no latch is inferred.
  always_comb begin
    rd_hit = 1'b0;
    rd_val = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_idx == AW'(i)) begin
        rd_hit = 1'b1;
        rd_val = RO_MASK[i] ? sts_i[i*WIDTH +: WIDTH] : regs[i];
      end
    end
  end

  always_comb begin
    d0_hit = 1'b0;
    d0_ro  = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (d0_idx == AW'(i)) begin
        d0_hit = 1'b1;
        d0_ro  = RO_MASK[i];
      end
    end
    for (int k = 0; k < 4; k++) d0_bmask[8*k +: 8] = {8{d0_sel[k]}};
  end

  assign d0_legal = d0_valid & d0_hit & ~d0_ro;
  // A write only counts as a write if some selected lane lands inside WIDTH.
  assign d0_any   = |d0_bmask[WIDTH-1:0];

  // NOTE: the register array is small flop storage, so every entry is reset
  // to RESET_VAL; it is not a RAM macro.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
    end else if (d0_legal) begin
      for (int i = 0; i < NREGS; i++) begin
        if (d0_idx == AW'(i) && !RO_MASK[i])
          regs[i] <= (regs[i] & ~d0_bmask[WIDTH-1:0]) | (d0_dat & d0_bmask[WIDTH-1:0]);
      end
    end
  end

  // NOTE: all state here uses non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      wb_dat_o  <= '0;
      ctrl_wr_o <= '0;
      rip       <= 1'b0;
      wip       <= 1'b0;
      wr_done_q <= 1'b0;
      d0_valid  <= 1'b0;
      d0_idx    <= '0;
      d0_sel    <= '0;
      d0_dat    <= '0;
    end else begin
      wb_ack_o <= (rd_req & rd_hit) | d0_legal;
      wb_err_o <= (rd_req & ~rd_hit) | (d0_valid & ~d0_legal);
      if (rd_req) wb_dat_o <= 32'(rd_val);
      // A read always completes the cycle after acceptance.
      rip       <= rd_req;
      d0_valid  <= wr_req;
      wr_done_q <= d0_valid;
      if (wr_req) begin
        d0_idx <= wb_adr_i;
        d0_sel <= wb_sel_i;
        d0_dat <= wb_dat_i[WIDTH-1:0];
      end
      if (wr_req)         wip <= 1'b1;
      else if (wr_done_q) wip <= 1'b0;
      ctrl_wr_o <= '0;
      for (int i = 0; i < NREGS; i++) begin
        if (d0_legal && d0_any && d0_idx == AW'(i)) ctrl_wr_o[i] <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_ctrl
    assign ctrl_o[i*WIDTH +: WIDTH] = RO_MASK[i] ? '0 : regs[i];
  end

endmodule

// File: tb/tb_wb_regbank_n.sv
// Scoreboard bench for wb_regbank_n: two instances (4x32 with an RO register,
// 3x8 with an unmapped slot) share one bus; a monitor checks responses.
module tb_wb_regbank_n;

  logic clk_i = 1'b0;
  logic rst_i;
  logic cyc, stb, we;
  logic [3:2]  adr;
  logic [3:0]  sel;
  logic [31:0] dat;
  logic tgt;

  logic a_ack, a_err, a_rty, a_stall;
  logic [31:0]  a_dat;
  logic [127:0] a_ctrl, sts_a;
  logic [3:0]   a_wr;

  logic b_ack, b_err, b_rty, b_stall;
  logic [31:0] b_dat;
  logic [23:0] b_ctrl, sts_b;
  logic [2:0]  b_wr;

  logic m_ack, m_err, m_stall;
  logic [31:0] m_dat;
  logic [3:0]  m_wr;

  always #5 clk_i = ~clk_i;

  wb_regbank_n #(.NREGS(4), .WIDTH(32), .RESET_VAL(32'hA5A5A5A5), .RO_MASK(4'b0100)) u_a (
    .clk_i(clk_i), .rst_i(rst_i), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_adr_i(adr),
    .wb_sel_i(sel), .wb_we_i(we), .wb_dat_i(dat), .wb_ack_o(a_ack), .wb_err_o(a_err),
    .wb_rty_o(a_rty), .wb_stall_o(a_stall), .wb_dat_o(a_dat), .ctrl_o(a_ctrl),
    .ctrl_wr_o(a_wr), .sts_i(sts_a));

  wb_regbank_n #(.NREGS(3), .WIDTH(8), .RESET_VAL(8'h00), .RO_MASK(3'b000)) u_b (
    .clk_i(clk_i), .rst_i(rst_i), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_adr_i(adr),
    .wb_sel_i(sel), .wb_we_i(we), .wb_dat_i(dat), .wb_ack_o(b_ack), .wb_err_o(b_err),
    .wb_rty_o(b_rty), .wb_stall_o(b_stall), .wb_dat_o(b_dat), .ctrl_o(b_ctrl),
    .ctrl_wr_o(b_wr), .sts_i(sts_b));

  assign m_ack   = tgt ? b_ack   : a_ack;
  assign m_err   = tgt ? b_err   : a_err;
  assign m_stall = tgt ? b_stall : a_stall;
  assign m_dat   = tgt ? b_dat   : a_dat;
  assign m_wr    = tgt ? {1'b0, b_wr} : a_wr;

  typedef struct {
    string       name;
    logic        err;
    logic        chk_dat;
    logic [31:0] dat;
    logic [3:0]  wr;
    int          cycle;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0;
  int n_total = 0;
  int cyc_n = 0;

  always @(posedge clk_i) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: pops one expectation per ack/err and checks kind, latency, data, strobe.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (m_ack || m_err) begin
        exp_t e;
        check("ack_err_exclusive", {31'd0, m_ack & m_err}, 32'd0);
        check("resp_expected", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check({e.name, "_err"}, {31'd0, m_err}, {31'd0, e.err});
          check({e.name, "_cycle"}, cyc_n, e.cycle);
          check({e.name, "_ctrl_wr"}, {28'd0, m_wr}, {28'd0, e.wr});
          if (e.chk_dat) check({e.name, "_dat"}, m_dat, e.dat);
        end
      end else begin
        check("ctrl_wr_idle", {28'd0, m_wr}, 32'd0);
      end
    end
  end

  task automatic bus(input string name, input logic w, input logic [1:0] a,
                     input logic [3:0] s, input logic [31:0] d, input logic e_err,
                     input logic [31:0] e_dat, input logic [3:0] e_wr);
    exp_t e;
    logic got;
    @(negedge clk_i);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
    e.name = name; e.err = e_err; e.chk_dat = !w; e.dat = e_dat; e.wr = e_wr;
    e.cycle = cyc_n + (w ? 2 : 1);
    sb.push_back(e);
    #1 check({name, "_stall_req"}, {31'd0, m_stall}, 32'd1);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk_i);
      if (m_ack || m_err) got = 1'b1;
    end
    check({name, "_resp_seen"}, {31'd0, got}, 32'd1);
    if (got) check({name, "_stall_ack"}, {31'd0, m_stall}, 32'd0);
    else sb.delete();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; tgt = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat = '0;
    sts_a = {32'h11111111, 32'hCAFE0001, 32'h22222222, 32'h33333333};
    sts_b = 24'hABCDEF;
    repeat (2) @(negedge clk_i);

    check("rst_ctrl0", a_ctrl[31:0],   32'hA5A5A5A5);
    check("rst_ctrl1", a_ctrl[63:32],  32'hA5A5A5A5);
    check("rst_ctrl2_ro", a_ctrl[95:64], 32'h00000000);
    check("rst_ctrl3", a_ctrl[127:96], 32'hA5A5A5A5);
    check("rst_ack",   {31'd0, a_ack},   32'd0);
    check("rst_err",   {31'd0, a_err},   32'd0);
    check("rst_stall", {31'd0, a_stall}, 32'd0);
    check("rst_dat",   a_dat,            32'd0);
    check("rty_tied",  {31'd0, a_rty},   32'd0);
    rst_i = 1'b0;

    bus("wr_a1",   1'b1, 2'd1, 4'hF, 32'h12345678, 1'b0, 32'h0, 4'b0010);
    check("ctrl1_after_wr", a_ctrl[63:32], 32'h12345678);
    bus("rd_a1",   1'b0, 2'd1, 4'h0, 32'h0, 1'b0, 32'h12345678, 4'b0000);
    bus("wr_a0_clr", 1'b1, 2'd0, 4'hF, 32'h00000000, 1'b0, 32'h0, 4'b0001);
    bus("wr_a0_lane2", 1'b1, 2'd0, 4'h4, 32'hFFFFFFFF, 1'b0, 32'h0, 4'b0001);
    check("ctrl0_lane2", a_ctrl[31:0], 32'h00FF0000);
    bus("rd_a0",   1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 32'h00FF0000, 4'b0000);
    bus("wr_a0_sel0", 1'b1, 2'd0, 4'h0, 32'h12121212, 1'b0, 32'h0, 4'b0000);
    check("ctrl0_sel0_unchanged", a_ctrl[31:0], 32'h00FF0000);
    bus("rd_a2_ro", 1'b0, 2'd2, 4'h0, 32'h0, 1'b0, 32'hCAFE0001, 4'b0000);
    bus("wr_a2_ro", 1'b1, 2'd2, 4'hF, 32'h55555555, 1'b1, 32'h0, 4'b0000);
    check("ctrl2_ro_zero", a_ctrl[95:64], 32'h00000000);
    bus("rd_a2_again", 1'b0, 2'd2, 4'h0, 32'h0, 1'b0, 32'hCAFE0001, 4'b0000);
    bus("rd_a3", 1'b0, 2'd3, 4'h0, 32'h0, 1'b0, 32'hA5A5A5A5, 4'b0000);

    // Reset lands one cycle after the write is accepted: no response may follow.
    @(negedge clk_i);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 2'd3; sel = 4'hF; dat = 32'h11111111;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1 check("midrst_stall_en", {31'd0, a_stall}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    #1 check("midrst_stall_drop", {31'd0, a_stall}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check("midrst_ctrl3", a_ctrl[127:96], 32'hA5A5A5A5);
    check("midrst_ctrl1_reset", a_ctrl[63:32], 32'hA5A5A5A5);
    check("midrst_sb_empty", sb.size(), 32'd0);

    // 3 x 8-bit instance: unmapped slot 3 and narrow width.
    tgt = 1'b1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("b_rst_ctrl", {8'd0, b_ctrl}, 32'd0);
    rst_i = 1'b0;
    bus("wr_b0", 1'b1, 2'd0, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0, 4'b0001);
    check("b_ctrl0", {24'd0, b_ctrl[7:0]}, 32'h000000FF);
    bus("rd_b0", 1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 32'h000000FF, 4'b0000);
    bus("rd_b3_unmapped", 1'b0, 2'd3, 4'h0, 32'h0, 1'b1, 32'h00000000, 4'b0000);
    bus("wr_b3_unmapped", 1'b1, 2'd3, 4'hF, 32'h12345678, 1'b1, 32'h0, 4'b0000);
    bus("wr_b1_hilane", 1'b1, 2'd1, 4'h2, 32'hFFFFFFFF, 1'b0, 32'h0, 4'b0000);
    check("b_ctrl_after", {8'd0, b_ctrl}, 32'h000000FF);

    repeat (3) @(negedge clk_i);
    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_regbank_n.md
# wb_regbank_n

Parametrised Wishbone (pipelined, 32-bit) register bank: NREGS registers of WIDTH bits, each either read/write control or read-only status. It is the next generation of the fixed two-register bank. It adds:
- byte-lane write masking via wb_sel_i
- a per-register write-strobe pulse
- read-only status registers
- bus errors for unmapped or illegal accesses

It sits behind the Wishbone crossbar and drives/observes user logic directly.

## Interface
Parameters:
- NREGS, 4, number of registers (2..64); AW = clog2(NREGS)
- WIDTH, 32, bits per register (1..32); data bits [WIDTH-1:0] used, upper bits read 0
- RESET_VAL, 0, WIDTH-bit reset value applied to every control register
- RO_MASK, 0, NREGS-bit mask; bit i = 1 makes register i read-only (reads sts_i slice i)

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_adr_i  in  [AW+1:2]  word address
- wb_sel_i  in  4  byte-lane selects
- wb_we_i  in  1  write enable
- wb_dat_i  in  32  write data
- wb_ack_o  out  1  transfer acknowledge
- wb_err_o  out  1  transfer error
- wb_rty_o  out  1  tied 0
- wb_stall_o  out  1  stall
- wb_dat_o  out  32  read data, registered
- ctrl_o  out  NREGS*WIDTH  register i at [i*WIDTH +: WIDTH]; RO slots drive 0
- ctrl_wr_o  out  NREGS  one-cycle pulse when register i is written
- sts_i  in  NREGS*WIDTH  status inputs, sampled only for RO registers

## Operation
- en = wb_cyc_i & wb_stb_i.
- rip/wip flags are set on an accepted read/write and cleared on the corresponding ack or err.
- A new request is accepted only when the matching flag is clear: rd_req = en & ~we & ~rip, wr_req = en & we & ~wip.
- Address decode: index = wb_adr_i.
  - index >= NREGS → unmapped.
  - Write to a register with RO_MASK[index] = 1 → illegal.
- Read path, combinational decode registered in one stage:
  - wb_dat_o = zero-extended register value, or sts_i slice for RO registers.
  - Unmapped reads return 0 and raise err instead of ack.
- Write path: request, address, data and sel are registered into a d0 stage. In the following cycle the selected register updates byte lanes k with wb_sel_i[k] = 1; lanes at or above WIDTH are ignored.
- ctrl_wr_o[index] pulses in the same cycle as the write ack, only if at least one sel bit covering [WIDTH-1:0] was set.
- sel == 0 writes are acked with no update and no pulse.
- Unmapped or RO writes: no update, no pulse, err in place of ack.
- wb_stall_o = en & ~(wb_ack_o | wb_err_o).
- ack and err are never asserted together.
- Read and write can be in flight simultaneously, one of each. If both complete in the same cycle, both are ORed onto the shared ack/err outputs; the master must not issue this (single-outstanding masters only).
- Deassertion of wb_cyc_i does not cancel an accepted transfer; its ack/err still fires.

## Timing
- Read accepted in cycle T → wb_ack_o/wb_err_o high for exactly one cycle in T+1, with wb_dat_o valid in T+1.
- Write accepted in cycle T:
  - d0 stage registered at the end of T.
  - Register updated at the end of T+1; new ctrl_o visible in T+2.
  - wb_ack_o/wb_err_o and ctrl_wr_o high in T+2.
- Back-to-back reads: one per 2 cycles; back-to-back writes: one per 3 cycles, throttled by stall.
- Reset values (asynchronous, immediate):
  - ack, err, wb_dat_o, ctrl_wr_o, rip, wip, d0 stage = 0.
  - Control registers = RESET_VAL.
- rst_i asserted mid-transfer drops the transfer; no ack/err is issued after reset release.

## Test plan
- Reset with NREGS=4, WIDTH=32, RESET_VAL=0xA5A5A5A5 → all ctrl_o slices 0xA5A5A5A5, ack/err/stall 0, wb_dat_o 0.
- Write 0x12345678, sel=0xF to addr 1, then read addr 1 → ack in T+2, ctrl_wr_o=0b0010 for one cycle, ctrl_o[63:32]=0x12345678; read ack in T+1 with wb_dat_o=0x12345678.
- Write 0xFFFFFFFF, sel=0x4 to addr 0 (reg = 0) → reg 0 = 0x00FF0000. Write with sel=0 → ack, no change, no pulse.
- RO_MASK=0b0100, sts_i slice 2 = 0xCAFE0001: read addr 2 returns 0xCAFE0001 with ack; write addr 2 → err in T+2, no update, no ctrl_wr_o.
- NREGS=3: read addr 3 → err in T+1, wb_dat_o=0; write addr 3 → err in T+2. WIDTH=8: write 0xFFFFFFFF to addr 0 reads back 0x000000FF.
- Assert rst_i one cycle after a write is accepted → no ack/err afterwards, register keeps RESET_VAL, stall drops once en drops.
